microwave_countdown_timer: RTL and testbench
============================================

# microwave_countdown_timer

Countdown stage directly downstream of the ÷100 frequency divider in the microwave controller. It consumes the divider's slow square-wave output as its time base and counts a loaded MM:SS BCD value down to 00:00. It exposes the digits for the display driver and a magnetron enable for the power stage. A small FSM gates counting on start, pause, clear and door state.

## Interface
- BEEP_TICKS, 3: number of time-base ticks the done beep stays asserted; 1..15 (only meaningful with DONE_BEEP_EN).
- clk  in  1  system clock, same domain as the divider.
- rst_n  in  1  asynchronous active-low reset.
- tick_in  in  1  divider output (synchronous to clk); each rising edge is one count tick.
- load  in  1  single-cycle strobe; captures the four load digits.
- min_tens_in, min_ones_in, sec_tens_in, sec_ones_in  in  4 each  BCD load value.
- start  in  1  level/strobe; begin or resume counting.
- pause  in  1  strobe; suspend counting.
- clear  in  1  strobe; abort, zero count, return to IDLE.
- door_closed  in  1  high when the door is shut.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  current count, BCD.
- running  out  1  high in RUNNING.
- magnetron_on  out  1  equals running.
- done  out  1  one-cycle pulse on reaching 00:00.
- load_err  out  1  one-cycle pulse when a load is rejected.
- beep  out  1  audible alert (see Configuration).

## Operation
- Tick detect: register tick_q <= tick_in; tick_rise = tick_in & ~tick_q. tick_q resets to 0.
- States: IDLE, RUNNING, PAUSED, DONE.
- Priority per cycle: clear > door_closed==0 > pause > start > load > tick.
- clear (any state): count <= 00:00, state <= IDLE, beep off.
- IDLE: load with valid digits captures them. Valid means every digit ≤ 9 and sec_tens ≤ 5. An invalid load leaves the count unchanged and pulses load_err. start with door_closed=1 and count ≠ 00:00 -> RUNNING. start with count = 00:00 is ignored.
- RUNNING: on tick_rise, decrement with borrow: sec_ones 0->9 borrows sec_tens; sec_tens 0->5 borrows min_ones; min_ones 0->9 borrows min_tens (e.g. 10:00 -> 09:59). A tick that produces 00:00 moves the state to DONE on the same edge and pulses done. pause -> PAUSED. door_closed=0 -> PAUSED. A tick in the same cycle as pause or door-open is discarded.
- PAUSED: start with door_closed=1 -> RUNNING. Ticks, load and pause are ignored.
- DONE: count holds 00:00. clear, load or door open -> IDLE. A valid load in DONE also captures the new value.
- Outputs are registered. running and magnetron_on are decoded from the state register.

## Timing
- Reset values: state IDLE, all digits 0, running 0, magnetron_on 0, done 0, load_err 0, beep 0, tick_q 0.
- Tick latency: tick_in first high in cycle N -> new digits visible in cycle N+1. The tick is not re-counted while tick_in stays high.
- Load latency: digits visible the cycle after the load strobe.
- start -> running=1 the next cycle. The first decrement occurs on the next tick_rise after entry.
- done and load_err are high for exactly one clk cycle.
- Reset asserted mid-count forces all outputs to their reset values immediately, independent of clk.

## Configuration
- DONE_BEEP_EN defined: beep rises with done and stays high for BEEP_TICKS tick_rise events, then falls. clear, or a load/start leaving DONE, cuts it off immediately.
- DONE_BEEP_EN undefined: beep is tied to 0 and no beep counter is synthesized.

## Test plan
- Reset mid-run: load 00:05, start, assert rst_n=0 after 2 ticks -> digits 00:00, state IDLE, running 0 asynchronously.
- Borrow chain: load 10:00, start, 1 tick -> 09:59; load 01:00, 1 tick -> 00:59.
- Terminal count: load 00:02, start, 2 ticks -> 00:00, done pulses once, running 0. Further ticks leave 00:00 and no more done pulses.
- Door/pause: load 00:10, start, 3 ticks -> 00:07. Drop door_closed in the same cycle as a tick -> stays 00:07, PAUSED. Close door and start, 1 tick -> 00:06.
- Invalid load: load 00:7 with sec_tens=6 -> load_err pulse, count unchanged. Load 99:59 -> accepted. Start with 00:00 -> stays IDLE.
- DONE_BEEP_EN with BEEP_TICKS=3: reach 00:00 -> beep high for 3 ticks, then 0. Clear during the beep -> beep 0 next cycle. Without the macro, beep is always 0.

Source files
------------

// File: rtl/microwave_countdown_timer_if.sv
// microwave_countdown_timer_if
//   Signal bundle between the microwave controller and the countdown timer.
//   master : controller side (drives tick/load/start/pause/clear/door, reads count and status)
//   slave  : timer side (reads the controls, drives count and status)
//   Control : tick_in, load, min_tens_in, min_ones_in, sec_tens_in, sec_ones_in,
//             start, pause, clear, door_closed
//   Status  : min_tens, min_ones, sec_tens, sec_ones, running, magnetron_on,
//             done, load_err, beep
interface microwave_countdown_timer_if;
    logic       tick_in;
    logic       load;
    logic [3:0] min_tens_in;
    logic [3:0] min_ones_in;
    logic [3:0] sec_tens_in;
    logic [3:0] sec_ones_in;
    logic       start;
    logic       pause;
    logic       clear;
    logic       door_closed;

    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       magnetron_on;
    logic       done;
    logic       load_err;
    logic       beep;

    modport master (
        output tick_in, load, min_tens_in, min_ones_in, sec_tens_in, sec_ones_in,
               start, pause, clear, door_closed,
        input  min_tens, min_ones, sec_tens, sec_ones, running, magnetron_on,
               done, load_err, beep
    );

    modport slave (
        input  tick_in, load, min_tens_in, min_ones_in, sec_tens_in, sec_ones_in,
               start, pause, clear, door_closed,
        output min_tens, min_ones, sec_tens, sec_ones, running, magnetron_on,
               done, load_err, beep
    );
endinterface

// File: rtl/microwave_countdown_timer.sv
// microwave_countdown_timer
//   Counts a loaded MM:SS BCD value down to 00:00, one step per rising edge of
//   the divider output tick_in. A four-state FSM (IDLE/RUNNING/PAUSED/DONE)
//   gates counting on start, pause, clear and the door switch.
//   Ports:
//     clk    system clock (same domain as the divider)
//     rst_n  asynchronous active-low reset
//     bus    microwave_countdown_timer_if.slave (controls in, count/status out)
//   Parameter:
//     BEEP_TICKS  time-base ticks the done beep stays high (1..15)
//   Build option:
//     DONE_BEEP_EN  when defined, beep rises with done and lasts BEEP_TICKS
//                   ticks; when undefined, beep is tied low.
module microwave_countdown_timer #(
    parameter int unsigned BEEP_TICKS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    microwave_countdown_timer_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

    if (BEEP_TICKS < 1 || BEEP_TICKS > 15) begin : g_beep_ticks_range
        $error("BEEP_TICKS must be in 1..15");
    end

    state_t      state, state_d;
    logic [15:0] cnt_q, cnt_d;          // {min_tens, min_ones, sec_tens, sec_ones}
    logic        done_q, done_d;
    logic        load_err_q, load_err_d;
    logic        tick_q;
    logic        tick_rise;
    logic [15:0] load_val;
    logic        load_ok;
    logic        cnt_zero;
    logic [15:0] cnt_dec;

    // BCD decrement with borrow through 59-second minutes. Only applied to a
    // non-zero count, so min_tens never underflows.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = v;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign tick_rise = bus.tick_in & ~tick_q;
    assign load_val  = {bus.min_tens_in, bus.min_ones_in, bus.sec_tens_in, bus.sec_ones_in};
    assign load_ok   = (bus.min_tens_in <= 4'd9) && (bus.min_ones_in <= 4'd9) &&
                       (bus.sec_tens_in <= 4'd5) && (bus.sec_ones_in <= 4'd9);
    assign cnt_zero  = (cnt_q == '0);
    assign cnt_dec   = bcd_dec(cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state      <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
            tick_q     <= bus.tick_in;
        end
    end

    // Priority: clear > door open > pause > start > load > tick.
    // start is allowed to be held as a level, so it never masks a tick in RUNNING.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.pause) begin
                        if (bus.start) begin
                            if (bus.door_closed && !cnt_zero) begin
                                state_d = RUNNING;
                            end
                        end else if (bus.load) begin
                            if (load_ok) begin
                                cnt_d = load_val;
                            end else begin
                                load_err_d = 1'b1;
                            end
                        end
                    end
                end
                RUNNING: begin
                    if (!bus.door_closed || bus.pause) begin
                        state_d = PAUSED;
                    end else if (tick_rise) begin
                        cnt_d = cnt_dec;
                        if (cnt_dec == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (bus.door_closed && !bus.pause && bus.start) begin
                        state_d = RUNNING;
                    end
                end
                DONE: begin
                    if (!bus.door_closed) begin
                        state_d = IDLE;
                    end else if (!bus.pause) begin
                        if (bus.start) begin
                            state_d = IDLE;
                        end else if (bus.load) begin
                            state_d = IDLE;
                            if (load_ok) begin
                                cnt_d = load_val;
                            end else begin
                                load_err_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

`ifdef DONE_BEEP_EN
    logic [3:0] beep_cnt;
    logic       beep_q;
    logic       beep_cut;

    // Cut the beep on clear, or when a start/load takes the FSM out of DONE.
    assign beep_cut = bus.clear ||
                      ((state == DONE) && bus.door_closed && !bus.pause &&
                       (bus.start || bus.load));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_q   <= 1'b0;
            beep_cnt <= '0;
        end else if (beep_cut) begin
            beep_q   <= 1'b0;
            beep_cnt <= '0;
        end else if (done_d) begin
            beep_q   <= 1'b1;
            beep_cnt <= 4'(BEEP_TICKS);
        end else if (beep_q && tick_rise) begin
            if (beep_cnt == 4'd1) begin
                beep_q <= 1'b0;
            end
            beep_cnt <= beep_cnt - 4'd1;
        end
    end

    assign bus.beep = beep_q;
`else
    assign bus.beep = 1'b0;
`endif

    assign {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones} = cnt_q;
    assign bus.running      = (state == RUNNING);
    assign bus.magnetron_on = (state == RUNNING);
    assign bus.done         = done_q;
    assign bus.load_err     = load_err_q;

endmodule

// File: tb/tb_microwave_countdown_timer.sv
// tb_microwave_countdown_timer
//   Table of one-cycle vectors {controls, expected count/running/done/load_err}
//   applied in order, plus hand-written sequences for asynchronous reset
//   mid-count and the done beep.
module tb_microwave_countdown_timer;

`ifdef DONE_BEEP_EN
    localparam logic BEEP_ON = 1'b1;
`else
    localparam logic BEEP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    microwave_countdown_timer_if bus();

    microwave_countdown_timer #(.BEEP_TICKS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        tk;
        logic        ld;
        logic [15:0] din;
        logic        st;
        logic        pa;
        logic        cl;
        logic        door;
        logic [15:0] q;
        logic        run;
        logic        dn;
        logic        lerr;
    } vec_t;

    vec_t vt[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [15:0] digits();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic v(input logic tk, input logic ld, input logic [15:0] din,
                     input logic st, input logic pa, input logic cl, input logic door,
                     input logic [15:0] q, input logic run, input logic dn, input logic lerr);
        vec_t r;
        r.tk = tk; r.ld = ld; r.din = din; r.st = st; r.pa = pa; r.cl = cl; r.door = door;
        r.q = q; r.run = run; r.dn = dn; r.lerr = lerr;
        vt.push_back(r);
    endtask

    task automatic cyc(input logic tk, input logic ld, input logic [15:0] din,
                       input logic st, input logic pa, input logic cl, input logic door);
        bus.tick_in = tk;
        bus.load    = ld;
        {bus.min_tens_in, bus.min_ones_in, bus.sec_tens_in, bus.sec_ones_in} = din;
        bus.start       = st;
        bus.pause       = pa;
        bus.clear       = cl;
        bus.door_closed = door;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //  tk ld din       st pa cl dr   q         run dn le
        // borrow chain 10:00 -> 09:59, held tick not recounted
        v(0, 1, 16'h1000, 0, 0, 0, 1,   16'h1000, 0, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 0, 1,   16'h1000, 1, 0, 0);
        v(1, 0, 16'h0000, 0, 0, 0, 1,   16'h0959, 1, 0, 0);
        v(1, 0, 16'h0000, 0, 0, 0, 1,   16'h0959, 1, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 0, 1,   16'h0959, 1, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 1, 1,   16'h0000, 0, 0, 0);
        // 01:00 -> 00:59
        v(0, 1, 16'h0100, 0, 0, 0, 1,   16'h0100, 0, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 0, 1,   16'h0100, 1, 0, 0);
        v(1, 0, 16'h0000, 0, 0, 0, 1,   16'h0059, 1, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 0, 1,   16'h0059, 1, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 1, 1,   16'h0000, 0, 0, 0);
        // invalid load (sec_tens 6), valid 99:59, start at 00:00 ignored
        v(0, 1, 16'h0067, 0, 0, 0, 1,   16'h0000, 0, 0, 1);
        v(0, 0, 16'h0000, 0, 0, 0, 1,   16'h0000, 0, 0, 0);
        v(0, 1, 16'h9959, 0, 0, 0, 1,   16'h9959, 0, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 1, 1,   16'h0000, 0, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 0, 1,   16'h0000, 0, 0, 0);
        // terminal count 00:02 -> 00:00, single done pulse
        v(0, 1, 16'h0002, 0, 0, 0, 1,   16'h0002, 0, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 0, 1,   16'h0002, 1, 0, 0);
        v(1, 0, 16'h0000, 0, 0, 0, 1,   16'h0001, 1, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 0, 1,   16'h0001, 1, 0, 0);
        v(1, 0, 16'h0000, 0, 0, 0, 1,   16'h0000, 0, 1, 0);
        v(0, 0, 16'h0000, 0, 0, 0, 1,   16'h0000, 0, 0, 0);
        v(1, 0, 16'h0000, 0, 0, 0, 1,   16'h0000, 0, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 0, 1,   16'h0000, 0, 0, 0);
        // load in DONE captures and returns to IDLE; start then runs
        v(0, 1, 16'h0003, 0, 0, 0, 1,   16'h0003, 0, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 0, 1,   16'h0003, 1, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 1, 1,   16'h0000, 0, 0, 0);
        // door/pause: 00:10, 3 ticks -> 00:07
        v(0, 1, 16'h0010, 0, 0, 0, 1,   16'h0010, 0, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 0, 1,   16'h0010, 1, 0, 0);
        v(1, 0, 16'h0000, 0, 0, 0, 1,   16'h0009, 1, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 0, 1,   16'h0009, 1, 0, 0);
        v(1, 0, 16'h0000, 0, 0, 0, 1,   16'h0008, 1, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 0, 1,   16'h0008, 1, 0, 0);
        v(1, 0, 16'h0000, 0, 0, 0, 1,   16'h0007, 1, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 0, 1,   16'h0007, 1, 0, 0);
        // door opens with a tick: tick discarded, paused
        v(1, 0, 16'h0000, 0, 0, 0, 0,   16'h0007, 0, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 0, 0,   16'h0007, 0, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 0, 1,   16'h0007, 1, 0, 0);
        v(1, 0, 16'h0000, 0, 0, 0, 1,   16'h0006, 1, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 0, 1,   16'h0006, 1, 0, 0);
        // pause; ticks ignored while paused
        v(0, 0, 16'h0000, 0, 1, 0, 1,   16'h0006, 0, 0, 0);
        v(1, 0, 16'h0000, 0, 0, 0, 1,   16'h0006, 0, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 0, 1,   16'h0006, 0, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 0, 1,   16'h0006, 1, 0, 0);
        v(1, 0, 16'h0000, 0, 0, 0, 1,   16'h0005, 1, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 0, 1,   16'h0005, 1, 0, 0);
        // pause coincident with tick: tick discarded
        v(1, 0, 16'h0000, 0, 1, 0, 1,   16'h0005, 0, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 0, 1,   16'h0005, 0, 0, 0);
        // clear, then min_tens > 9 rejected
        v(0, 0, 16'h0000, 0, 0, 1, 1,   16'h0000, 0, 0, 0);
        v(0, 1, 16'hA000, 0, 0, 0, 1,   16'h0000, 0, 0, 1);
        v(0, 0, 16'h0000, 0, 0, 0, 1,   16'h0000, 0, 0, 0);

        // reset state
        rst_n = 1'b0;
        bus.tick_in = 0; bus.load = 0; bus.start = 0; bus.pause = 0; bus.clear = 0;
        bus.door_closed = 1;
        {bus.min_tens_in, bus.min_ones_in, bus.sec_tens_in, bus.sec_ones_in} = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset digits",   digits(),         16'h0000);
        chk("reset running",  bus.running,      16'h0);
        chk("reset magnetron",bus.magnetron_on, 16'h0);
        chk("reset done",     bus.done,         16'h0);
        chk("reset load_err", bus.load_err,     16'h0);
        chk("reset beep",     bus.beep,         16'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            cyc(vt[i].tk, vt[i].ld, vt[i].din, vt[i].st, vt[i].pa, vt[i].cl, vt[i].door);
            chk($sformatf("vec%0d digits", i),    digits(),         vt[i].q);
            chk($sformatf("vec%0d running", i),   bus.running,      16'(vt[i].run));
            chk($sformatf("vec%0d magnetron", i), bus.magnetron_on, 16'(vt[i].run));
            chk($sformatf("vec%0d done", i),      bus.done,         16'(vt[i].dn));
            chk($sformatf("vec%0d load_err", i),  bus.load_err,     16'(vt[i].lerr));
        end

        // asynchronous reset mid-count: 00:05, 2 ticks -> 00:03, then reset between edges
        cyc(0, 1, 16'h0005, 0, 0, 0, 1);
        cyc(0, 0, 16'h0000, 1, 0, 0, 1);
        cyc(1, 0, 16'h0000, 0, 0, 0, 1);
        cyc(0, 0, 16'h0000, 0, 0, 0, 1);
        cyc(1, 0, 16'h0000, 0, 0, 0, 1);
        cyc(0, 0, 16'h0000, 0, 0, 0, 1);
        chk("prereset digits",  digits(),    16'h0003);
        chk("prereset running", bus.running, 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst digits",    digits(),         16'h0000);
        chk("async rst running",   bus.running,      16'h0);
        chk("async rst magnetron", bus.magnetron_on, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1, 0, 16'h0000, 0, 0, 0, 1);
        chk("post rst idle digits",  digits(),    16'h0000);
        chk("post rst idle running", bus.running, 16'h0);
        cyc(0, 0, 16'h0000, 0, 0, 0, 1);

        // done beep lasts 3 tick rises
        cyc(0, 1, 16'h0001, 0, 0, 0, 1);
        cyc(0, 0, 16'h0000, 1, 0, 0, 1);
        cyc(1, 0, 16'h0000, 0, 0, 0, 1);
        chk("beep done",   bus.done, 16'h1);
        chk("beep start",  bus.beep, 16'(BEEP_ON));
        cyc(0, 0, 16'h0000, 0, 0, 0, 1);
        chk("beep hold0",  bus.beep, 16'(BEEP_ON));
        cyc(1, 0, 16'h0000, 0, 0, 0, 1);
        chk("beep tick1",  bus.beep, 16'(BEEP_ON));
        cyc(0, 0, 16'h0000, 0, 0, 0, 1);
        cyc(1, 0, 16'h0000, 0, 0, 0, 1);
        chk("beep tick2",  bus.beep, 16'(BEEP_ON));
        cyc(0, 0, 16'h0000, 0, 0, 0, 1);
        chk("beep hold2",  bus.beep, 16'(BEEP_ON));
        cyc(1, 0, 16'h0000, 0, 0, 0, 1);
        chk("beep tick3",  bus.beep, 16'h0);
        cyc(0, 0, 16'h0000, 0, 0, 0, 1);
        chk("beep after",  bus.beep, 16'h0);

        // clear cuts the beep
        cyc(0, 1, 16'h0001, 0, 0, 0, 1);
        cyc(0, 0, 16'h0000, 1, 0, 0, 1);
        cyc(1, 0, 16'h0000, 0, 0, 0, 1);
        chk("beep2 start", bus.beep, 16'(BEEP_ON));
        cyc(0, 0, 16'h0000, 0, 0, 1, 1);
        chk("beep2 clear", bus.beep, 16'h0);
        cyc(1, 0, 16'h0000, 0, 0, 0, 1);
        chk("beep2 stays", bus.beep, 16'h0);
        cyc(0, 0, 16'h0000, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
